// File: rtl/alu_seq_ctrl_if.sv
// Request/status bundle plus the operand/result wires to the external ALU.
interface alu_seq_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic [31:0] iter_count;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_cout;

  modport slave (
    input  start, op, a, b, alu_result, alu_cout,
    output busy, done, result, div_zero, iter_count, alu_op, alu_a, alu_b
  );

  modport master (
    output start, op, a, b, alu_result, alu_cout,
    input  busy, done, result, div_zero, iter_count, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer around an external 32-bit ALU: one EXEC cycle for logic/arith ops,
// unsigned mod by repeated subtraction using the ALU carry-out as the rem>=b test.
module alu_seq_ctrl (
  input  logic           clk,
  input  logic           reset,
  alu_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MOD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  logic [1:0]  state;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] rem;
  logic [31:0] result_r;
  logic [31:0] iter_r;
  logic        dz_r;
  logic        accept;

  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      rem      <= '0;
      result_r <= '0;
      iter_r   <= '0;
      dz_r     <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          result_r <= bus.alu_result;
          dz_r     <= 1'b0;
          state    <= S_DONE;
        end
        S_MOD: begin
          // carry-out of rem - b_r is set exactly when rem >= b_r (unsigned)
          if (bus.alu_cout) begin
            rem    <= bus.alu_result;
            iter_r <= iter_r + 32'd1;
          end else begin
            result_r <= rem;
            state    <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= bus.b;
            if (bus.op != OP_MOD) begin
              state <= S_EXEC;
            end else if (bus.b == 32'd0) begin
              result_r <= bus.a;
              dz_r     <= 1'b1;
              iter_r   <= '0;
              state    <= S_DONE;
            end else begin
              rem    <= bus.a;
              iter_r <= '0;
              dz_r   <= 1'b0;
              state  <= S_MOD;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.alu_op = 3'b000;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    case (state)
      S_EXEC: begin
        bus.alu_op = op_r;
        bus.alu_a  = a_r;
        bus.alu_b  = b_r;
      end
      S_MOD: begin
        bus.alu_op = OP_SUB;
        bus.alu_a  = rem;
        bus.alu_b  = b_r;
      end
      default: ;
    endcase
  end

  assign bus.busy       = (state == S_EXEC) || (state == S_MOD);
  assign bus.done       = (state == S_DONE);
  assign bus.result     = result_r;
  assign bus.div_zero   = dz_r;
  assign bus.iter_count = iter_r;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU on the ALU wires, scoreboard of expected completions.
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus();
  alu_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic        dz;
    logic [31:0] it;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_res  = '0;
  logic [31:0] last_iter = '0;

  function automatic logic [32:0] alu_f(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000:  return {1'b0, x & y};
      3'b001:  return {1'b0, x | y};
      3'b010:  return {1'b0, x ^ y};
      3'b011:  return {1'b0, ~(x | y)};
      3'b100:  return {1'b0, 31'd0, ($signed(x) < $signed(y))};
      3'b101:  return {1'b0, x} + {1'b0, y};
      3'b110:  return {1'b0, x} + {1'b0, ~y} + 33'd1;
      default: return 33'd0;
    endcase
  endfunction

  always_comb {bus.alu_cout, bus.alu_result} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Drives one request; returns while the DUT sits in DONE so a caller may chain another.
  task automatic run_req(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit poke);
    exp_t        e;
    logic [32:0] t;
    logic [31:0] rem;
    int          cyc;
    int          nmod;
    int          expc;
    bit          saw_sub;
    t = alu_f(o, x, y);
    if (o != 3'b111) begin
      e.res = t[31:0]; e.dz = 1'b0; e.it = last_iter; expc = 2;
    end else if (y == 32'd0) begin
      e.res = x; e.dz = 1'b1; e.it = 32'd0; expc = 1;
    end else begin
      e.res = x % y; e.dz = 1'b0; e.it = x / y; expc = int'(x / y) + 2;
    end
    sb.push_back(e);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; nmod = 0; saw_sub = 1'b0; rem = x;
    while (!bus.done && cyc < 5000) begin
      if (bus.alu_op == 3'b110) saw_sub = 1'b1;
      chk("busy_in_flight", {31'd0, bus.busy}, 32'd1);
      if (o == 3'b111) begin
        chk("mod_alu_op", {29'd0, bus.alu_op}, 32'd6);
        chk("mod_alu_a", bus.alu_a, rem);
        chk("mod_alu_b", bus.alu_b, y);
        if (rem >= y) rem = rem - y;
        nmod++;
        if (poke && nmod == 3) begin
          bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'hffff; bus.b = 32'h1234;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        chk("exec_alu_op", {29'd0, bus.alu_op}, {29'd0, o});
        chk("exec_alu_a", bus.alu_a, x);
        chk("exec_alu_b", bus.alu_b, y);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", cyc, expc);
      if (o == 3'b111 && y == 32'd0) chk("no_sub_on_div0", {31'd0, saw_sub}, 32'd0);
      chk("done_alu_op", {29'd0, bus.alu_op}, 32'd0);
      chk("done_busy", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
        chk("iter_count", bus.iter_count, e.it);
        last_res  = e.res;
        last_iter = e.it;
      end
    end
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_pulse_one", {31'd0, bus.done}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("hold_result", bus.result, last_res);
    chk("hold_iter", bus.iter_count, last_iter);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_div_zero"}, {31'd0, bus.div_zero}, 32'd0);
    chk({tag, "_iter"}, bus.iter_count, 32'd0);
    chk({tag, "_alu_op"}, {29'd0, bus.alu_op}, 32'd0);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    // reset wins over a simultaneous start
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'd1; bus.b = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    check_zero("post_reset_idle");

    run_req(3'b101, 32'd7, 32'd8, 1'b0);         idle_check();
    run_req(3'b111, 32'd17, 32'd5, 1'b0);        idle_check();
    run_req(3'b111, 32'd9, 32'd0, 1'b0);         idle_check();
    run_req(3'b111, 32'd100, 32'd7, 1'b1);       idle_check();
    run_req(3'b101, 32'd7, 32'd8, 1'b0);
    run_req(3'b110, 32'd5, 32'd3, 1'b0);         idle_check();
    run_req(3'b111, 32'd3, 32'd10, 1'b0);        idle_check();
    run_req(3'b011, 32'h0f0f_0000, 32'h0000_00ff, 1'b0); idle_check();

    // reset in the 3rd MOD cycle of 1000 mod 3
    bus.start = 1'b1; bus.op = 3'b111; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mod_alu_a", bus.alu_a, 32'd994);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("mid_mod_reset");
    last_res = '0; last_iter = '0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", {31'd0, bus.done}, 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'b111) begin
        ra = $urandom_range(0, 300);
        rb = $urandom_range(0, 20);
      end else begin
        ra = $urandom();
        rb = $urandom();
      end
      run_req(ro, ra, rb, 1'b0);
      if (i % 3 != 0) idle_check();
    end
    idle_check();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
